maxpool_2x2_stream: RTL and testbench
=====================================

MAXPOOL_2X2_STREAM -- requirements
Module: maxpool_2x2_stream

Interface
REQ-001 SHALL have parameter IN_Width, default 4: columns per input row, meaning the conv output width; legal range ≥2.
REQ-002 SHALL have parameter IN_Height, default 4: rows per input frame; legal range ≥2.
REQ-003 SHALL have parameter Datawidth, default 32: sample width, two's-complement signed.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port valid_in, input, 1: In carries a valid raster-order sample; connected to the 3-channel conv valid_out.
REQ-007 SHALL have port In, input, Datawidth: input sample; connected to the 3-channel conv Out.
REQ-008 SHALL have port Out, output, Datawidth: pooled sample.
REQ-009 SHALL have port valid_out, output, 1: one-cycle strobe qualifying Out.
REQ-010 SHALL have port frame_done, output, 1: one-cycle strobe asserted together with the last pooled sample of a frame.

Function
REQ-011 SHALL compute 2x2 max pooling with stride 2 over a raster stream; output size is floor(IN_Width/2) x floor(IN_Height/2).
REQ-012 SHALL keep a column counter (0..IN_Width-1) and a row counter (0..IN_Height-1); both advance only when valid_in=1; column wraps to 0 and increments row; row wraps to 0 at end of frame.
REQ-013 SHALL accept arbitrary gaps in valid_in with all state held; there is no backpressure.
REQ-014 SHALL, on even columns, register the sample in a hold register; on odd columns, form pair_max = signed max(hold, In).
REQ-015 SHALL implement an FSM with states FILL (even row), EMIT (odd row), and SKIP (final row when IN_Height is odd); the reset state is FILL.
REQ-016 SHALL, in FILL, write pair_max into line-buffer entry col>>1 (depth floor(IN_Width/2)); it transitions to EMIT on row wrap.
REQ-017 SHALL, in EMIT at an odd column, register Out = signed max(linebuf[col>>1], pair_max) and assert valid_out on the next cycle (latency 1 clock from the completing valid_in).
REQ-018 SHALL, at the end of an EMIT row, go to FILL if at least 2 rows remain, to SKIP if exactly 1 row remains, and to FILL at frame wrap.
REQ-019 SHALL, in SKIP, consume samples without output and return to FILL at frame wrap.
REQ-020 SHALL, when IN_Width is odd, count but otherwise ignore the last column of each row.
REQ-021 SHALL assert frame_done in the same cycle as valid_out for pooled position (last row, last column).
REQ-022 SHALL hold Out at its last value when valid_out=0; when inputs are equal, the result is that value.
REQ-023 SHALL use full-width signed comparison with no truncation or saturation; output width equals Datawidth.

Reset
REQ-024 SHALL, while rst=0, clear counters, the hold register, Out, valid_out and frame_done to 0, and put the FSM in FILL; line-buffer contents need not be cleared.
REQ-025 SHALL, on reset asserted mid-frame, abandon the partial frame; the first valid_in after release is treated as position (0,0).

Structure
REQ-026 SHALL place the FSM state encodings (FILL/EMIT/SKIP) and a signed-max function in a shared package, e.g. cnn_pkg.
REQ-027 SHALL derive output dimensions and line-buffer depth as localparams from the parameters.
REQ-028 SHALL instantiate one sub-module, max_cmp (Datawidth-parameterised signed 2-input max, combinational), for both the pair and vertical comparisons.

Verification
REQ-029 SHALL be checked with a 4x4 frame, values 1..16 raster, valid_in continuous -> Out 6,8,14,16, each valid_out 1 cycle after its completing input; frame_done with 16.
REQ-030 SHALL be checked with a 4x4 frame of negatives −1..−16 -> Out −1,−3,−9,−11, confirming signed compare.
REQ-031 SHALL be checked with 5x5 (IN_Width=IN_Height=5), values 1..25 -> Out 7,9,17,19 only; column 5 and row 5 produce no output; the next frame restarts correctly.
REQ-032 SHALL be checked with the 1..16 frame and valid_in toggled 1-0-0-1 randomly -> identical Out sequence to REQ-029; no spurious valid_out.
REQ-033 SHALL be checked with rst pulsed low after 6 samples of a frame, then a fresh 1..16 frame -> outputs 6,8,14,16; all outputs 0 during reset.
REQ-034 SHALL be checked with two back-to-back 4x4 frames (1..16, then 16..1) -> 6,8,14,16 then 16,14,8,6; frame_done asserted exactly twice.

Source files
------------

// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared definitions for the 2x2 max-pooling stream: FSM encodings and a signed max helper.
package maxpool_2x2_stream_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_SKIP = 2'd2
  } pool_state_t;

  // Widest sample the helper handles; narrower samples are sign-extended into it.
  localparam int MAX_W = 64;

  function automatic logic signed [MAX_W-1:0] signed_max(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_max_cmp.sv
// Combinational two's-complement max of two samples; ties return the shared value.
module max_cmp
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int Datawidth = 32
) (
  input  logic signed [Datawidth-1:0] a,
  input  logic signed [Datawidth-1:0] b,
  output logic signed [Datawidth-1:0] y
);

  // Select by equality against the sign-extended winner so no wide bits are left dangling.
  assign y = (signed_max(MAX_W'(a), MAX_W'(b)) == MAX_W'(a)) ? a : b;

endmodule

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-order sample stream with a one-row line buffer.
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int IN_Width  = 4,
  parameter int IN_Height = 4,
  parameter int Datawidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [Datawidth-1:0] In,
  output logic [Datawidth-1:0] Out,
  output logic                 valid_out,
  output logic                 frame_done
);

  localparam int OUT_W    = IN_Width / 2;
  localparam int OUT_H    = IN_Height / 2;
  localparam int LB_DEPTH = OUT_W;
  localparam int COL_W    = $clog2(IN_Width) + 1;
  localparam int ROW_W    = $clog2(IN_Height) + 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IN_Width - 1);
  localparam logic [COL_W-1:0] COL_PAIR_END  = COL_W'(2 * OUT_W);
  localparam logic [COL_W-1:0] COL_PAIR_LAST = COL_W'(2 * OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IN_Height - 1);
  localparam logic [ROW_W-1:0] ROW_PENULT    = ROW_W'(IN_Height - 2);
  localparam logic [ROW_W-1:0] ROW_EMIT_LAST = ROW_W'(2 * OUT_H - 1);

  pool_state_t state_reg, state_next;

  logic [COL_W-1:0]            col_reg;
  logic [ROW_W-1:0]            row_reg;
  logic signed [Datawidth-1:0] hold_reg;
  logic signed [Datawidth-1:0] lb_rd_reg;
  logic [Datawidth-1:0]        out_reg;
  logic                        valid_out_reg;
  logic                        frame_done_reg;
  logic signed [Datawidth-1:0] linebuf [LB_DEPTH];

  logic signed [Datawidth-1:0] pair_max;
  logic signed [Datawidth-1:0] vert_max;
  logic                        col_end, row_end, in_pair, even_take, odd_take, emit_now;
  logic [LB_AW-1:0]            lb_addr;

  assign col_end   = (col_reg == COL_LAST);
  assign row_end   = (row_reg == ROW_LAST);
  // A trailing odd column falls outside every pair and is only counted.
  assign in_pair   = (col_reg < COL_PAIR_END);
  assign even_take = valid_in && in_pair && !col_reg[0];
  assign odd_take  = valid_in && in_pair && col_reg[0];
  assign emit_now  = odd_take && (state_reg == ST_EMIT);
  assign lb_addr   = LB_AW'(col_reg >> 1);

  max_cmp #(.Datawidth(Datawidth)) u_pair_cmp (
    .a (hold_reg),
    .b (In),
    .y (pair_max)
  );

  max_cmp #(.Datawidth(Datawidth)) u_vert_cmp (
    .a (lb_rd_reg),
    .b (pair_max),
    .y (vert_max)
  );

  always_comb begin
    state_next = state_reg;
    if (valid_in && col_end) begin
      case (state_reg)
        ST_FILL: state_next = ST_EMIT;
        ST_EMIT: begin
          if (row_end)                   state_next = ST_FILL;
          else if (row_reg == ROW_PENULT) state_next = ST_SKIP;
          else                           state_next = ST_FILL;
        end
        ST_SKIP: state_next = ST_FILL;
        default: state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_FILL;
      col_reg        <= '0;
      row_reg        <= '0;
      hold_reg       <= '0;
      out_reg        <= '0;
      valid_out_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      valid_out_reg  <= emit_now;
      frame_done_reg <= emit_now && (col_reg == COL_PAIR_LAST) && (row_reg == ROW_EMIT_LAST);
      if (valid_in) begin
        if (col_end) begin
          col_reg <= '0;
          row_reg <= row_end ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
      if (even_take) hold_reg <= In;
      if (emit_now)  out_reg  <= vert_max;
    end
  end

  // Line buffer: the stored row entry is fetched on the even column so it is ready at the odd one.
  always_ff @(posedge clk) begin
    if (odd_take && (state_reg == ST_FILL)) linebuf[lb_addr] <= pair_max;
    if (even_take && (state_reg == ST_EMIT)) lb_rd_reg <= linebuf[lb_addr];
  end

  assign Out        = out_reg;
  assign valid_out  = valid_out_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream: 4x4 and 5x5 instances, gaps, mid-frame reset, back-to-back frames.
module tb_maxpool_2x2_stream;

  typedef struct {
    logic [31:0] d;
    logic        fd;
    logic        lat;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vin4 = 1'b0, vin5 = 1'b0;
  logic [31:0] din4 = '0, din5 = '0;
  logic [31:0] out4, out5;
  logic        vout4, vout5, fd4, fd5;

  obs_t q4[$];
  obs_t q5[$];
  int   fd4_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  maxpool_2x2_stream #(.IN_Width(4), .IN_Height(4), .Datawidth(32)) dut4 (
    .clk(clk), .rst(rst), .valid_in(vin4), .In(din4),
    .Out(out4), .valid_out(vout4), .frame_done(fd4)
  );

  maxpool_2x2_stream #(.IN_Width(5), .IN_Height(5), .Datawidth(32)) dut5 (
    .clk(clk), .rst(rst), .valid_in(vin5), .In(din5),
    .Out(out5), .valid_out(vout5), .frame_done(fd5)
  );

  // Capture every pooled output; lat records whether a sample was accepted on that same edge.
  always @(posedge clk) begin
    obs_t o;
    #1;
    if (vout4) begin
      o.d = out4; o.fd = fd4; o.lat = vin4;
      q4.push_back(o);
    end
    if (vout5) begin
      o.d = out5; o.fd = fd5; o.lat = vin5;
      q5.push_back(o);
    end
    if (fd4) fd4_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel5, input logic v, input logic [31:0] d);
    if (sel5) begin vin5 = v; din5 = d; end
    else      begin vin4 = v; din4 = d; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 32'hDEAD_BEEF);
    end
  endtask

  task automatic send(input bit sel5, input int n, input int start, input int step, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          drive(sel5, 1'b0, 32'hDEAD_BEEF);
        end
      end
      @(negedge clk);
      drive(sel5, 1'b1, 32'(start + i * step));
    end
  endtask

  task automatic expect_out(input bit sel5, input string tag, input int v, input bit fd);
    obs_t o;
    int   sz;
    sz = sel5 ? q5.size() : q4.size();
    checks++;
    assert (sz > 0) else begin
      errors++;
      $error("FAIL %s: observed=no output expected=%0d", tag, v);
    end
    if (sz > 0) begin
      o = sel5 ? q5.pop_front() : q4.pop_front();
      check({tag, ".data"}, o.d, 32'(v));
      check({tag, ".frame_done"}, {31'b0, o.fd}, {31'b0, fd});
      check({tag, ".latency"}, {31'b0, o.lat}, 32'd1);
    end
  endtask

  task automatic expect_empty(input bit sel5, input string tag);
    check(tag, 32'(sel5 ? q5.size() : q4.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset.out4", out4, 32'd0);
    check("reset.vout4", {31'b0, vout4}, 32'd0);
    check("reset.fd4", {31'b0, fd4}, 32'd0);
    check("reset.out5", out5, 32'd0);
    check("reset.vout5", {31'b0, vout5}, 32'd0);
    check("reset.fd5", {31'b0, fd5}, 32'd0);
    rst = 1'b1;
    idle(2);

    // 1..16 continuous
    send(1'b0, 16, 1, 1, 1'b0);
    idle(3);
    expect_out(1'b0, "s1.o0", 6, 1'b0);
    expect_out(1'b0, "s1.o1", 8, 1'b0);
    expect_out(1'b0, "s1.o2", 14, 1'b0);
    expect_out(1'b0, "s1.o3", 16, 1'b1);
    expect_empty(1'b0, "s1.extra");
    check("s1.hold_out", out4, 32'd16);
    check("s1.hold_vout", {31'b0, vout4}, 32'd0);

    // -1..-16 signed compare
    send(1'b0, 16, -1, -1, 1'b0);
    idle(3);
    expect_out(1'b0, "s2.o0", -1, 1'b0);
    expect_out(1'b0, "s2.o1", -3, 1'b0);
    expect_out(1'b0, "s2.o2", -9, 1'b0);
    expect_out(1'b0, "s2.o3", -11, 1'b1);
    expect_empty(1'b0, "s2.extra");

    // 5x5 twice: odd trailing column and row produce nothing
    send(1'b1, 25, 1, 1, 1'b0);
    send(1'b1, 25, 1, 1, 1'b0);
    idle(3);
    for (int f = 0; f < 2; f++) begin
      expect_out(1'b1, $sformatf("s3.f%0d.o0", f), 7, 1'b0);
      expect_out(1'b1, $sformatf("s3.f%0d.o1", f), 9, 1'b0);
      expect_out(1'b1, $sformatf("s3.f%0d.o2", f), 17, 1'b0);
      expect_out(1'b1, $sformatf("s3.f%0d.o3", f), 19, 1'b1);
    end
    expect_empty(1'b1, "s3.extra");

    // 1..16 with random idle gaps
    send(1'b0, 16, 1, 1, 1'b1);
    idle(3);
    expect_out(1'b0, "s4.o0", 6, 1'b0);
    expect_out(1'b0, "s4.o1", 8, 1'b0);
    expect_out(1'b0, "s4.o2", 14, 1'b0);
    expect_out(1'b0, "s4.o3", 16, 1'b1);
    expect_empty(1'b0, "s4.extra");

    // reset after 6 samples; the partial frame already emitted the first pool
    send(1'b0, 6, 1, 1, 1'b0);
    idle(2);
    expect_out(1'b0, "s5.partial", 6, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("s5.rst.out4", out4, 32'd0);
    check("s5.rst.out5", out5, 32'd0);
    repeat (2) @(negedge clk);
    check("s5.rst2.out4", out4, 32'd0);
    check("s5.rst2.vout4", {31'b0, vout4}, 32'd0);
    check("s5.rst2.fd4", {31'b0, fd4}, 32'd0);
    rst = 1'b1;
    idle(1);
    send(1'b0, 16, 1, 1, 1'b0);
    idle(3);
    expect_out(1'b0, "s5.o0", 6, 1'b0);
    expect_out(1'b0, "s5.o1", 8, 1'b0);
    expect_out(1'b0, "s5.o2", 14, 1'b0);
    expect_out(1'b0, "s5.o3", 16, 1'b1);
    expect_empty(1'b0, "s5.extra");

    // back-to-back frames 1..16 then 16..1
    fd4_cnt = 0;
    send(1'b0, 16, 1, 1, 1'b0);
    send(1'b0, 16, 16, -1, 1'b0);
    idle(3);
    expect_out(1'b0, "s6.a0", 6, 1'b0);
    expect_out(1'b0, "s6.a1", 8, 1'b0);
    expect_out(1'b0, "s6.a2", 14, 1'b0);
    expect_out(1'b0, "s6.a3", 16, 1'b1);
    expect_out(1'b0, "s6.b0", 16, 1'b0);
    expect_out(1'b0, "s6.b1", 14, 1'b0);
    expect_out(1'b0, "s6.b2", 8, 1'b0);
    expect_out(1'b0, "s6.b3", 6, 1'b1);
    expect_empty(1'b0, "s6.extra");
    check("s6.frame_done_count", 32'(fd4_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
